// File: rtl/seg7_pkg.sv
// Shared types, constants and glyph table for the 7-segment scan display.
package seg7_pkg;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int         BCD_W     = 40;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_display_bin2bcd.sv
// Sequential double-dabble: 32 shift-add-3 iterations, one per clock, after a start pulse.
module bin2bcd_seq
  import seg7_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      value,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [31:0]      bin_q;
  logic [BCD_W-1:0] bcd_q;
  logic [BCD_W-1:0] adj;
  logic [4:0]       cnt_q;
  logic             busy_q;

  // Add 3 to every BCD nibble that is 5 or more before the next shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
  end

  // Load on start, then shift {bcd,bin} left once per cycle for 32 cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      bin_q  <= value;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      bcd_q <= {adj[BCD_W-2:0], bin_q[31]};
      bin_q <= {bin_q[30:0], 1'b0};
      cnt_q <= cnt_q + 5'd1;
      if (cnt_q == 5'd31) busy_q <= 1'b0;
    end
  end

  // done marks the cycle whose closing edge performs the final iteration.
  assign done = busy_q && (cnt_q == 5'd31);
  assign busy = busy_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/seg7_scan_display.sv
// 8-digit multiplexed common-anode display: snapshot, hex/decimal convert, double-buffer, scan.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int NUM_DIGITS  = 8,
  parameter int DATA_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_W-1:0]     display_syscall,
  input  logic [14:0]           display_pc,
  input  logic                  sel_pc,
  input  logic                  hex_mode,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  busy
);

  localparam int KEY_W = DATA_W + 2;
  localparam int PW    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW    = $clog2(NUM_DIGITS);
  localparam logic [PW-1:0]         PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [NUM_DIGITS-1:0] AN_ONE   = NUM_DIGITS'(1);

  state_t                          state;
  logic [DATA_W-1:0]               sel_value;
  logic [KEY_W-1:0]                key, key_q;
  logic                            snap_valid;
  logic                            capture, conv_start;
  logic                            conv_busy, conv_done;
  logic [BCD_W-1:0]                bcd;
  logic [NUM_DIGITS-1:0][3:0]      nib;
  logic                            ovf, lead;
  logic [NUM_DIGITS-1:0][7:0]      next_disp, disp_q;  // per digit {dp, seg}
  logic [PW-1:0]                   presc;
  logic [IW-1:0]                   idx;

  assign sel_value  = sel_pc ? DATA_W'(display_pc) : display_syscall;
  assign key        = {sel_pc, hex_mode, sel_value};
  assign capture    = (state == IDLE) && (!snap_valid || key != key_q);
  assign conv_start = capture && !hex_mode;

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .value (sel_value),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Build the next display image from the latched key (hex) or the BCD result (decimal).
  // Overflow keeps every digit lit since the true leading digit is off-panel.
  always_comb begin
    ovf       = 1'b0;
    lead      = 1'b1;
    next_disp = '1;
    if (key_q[DATA_W]) begin
      nib = key_q[4*NUM_DIGITS-1:0];
    end else begin
      nib = bcd[4*NUM_DIGITS-1:0];
      ovf = |bcd[BCD_W-1:4*NUM_DIGITS];
    end
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (nib[i] != 4'd0 || ovf) lead = 1'b0;
      next_disp[i] = {~(ovf && i == NUM_DIGITS - 1),
                      (lead && i != 0) ? SEG_BLANK : hex_to_seg(nib[i])};
    end
  end

  // Capture/convert/commit sequencer; the display buffer changes only in COMMIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      key_q      <= '0;
      snap_valid <= 1'b0;
      busy       <= 1'b0;
      disp_q     <= '1;  // all-ones is dp off + blank glyph on every digit
    end else begin
      case (state)
        IDLE: if (capture) begin
          key_q      <= key;
          snap_valid <= 1'b1;
          busy       <= 1'b1;
          state      <= hex_mode ? COMMIT : CONV;
        end
        CONV: if (conv_done || !conv_busy) state <= COMMIT;
        COMMIT: begin
          disp_q <= next_disp;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Digit scan: anode and segments for the current index are registered on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= '0;
      an    <= '1;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      an  <= ~(AN_ONE << idx);
      seg <= disp_q[idx][6:0];
      dp  <= disp_q[idx][7];
      if (presc == PRE_LAST) begin
        presc <= '0;
        idx   <= idx + 1'b1;
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench: behavioural display model compared every cycle, plus directed checks.
module tb_seg7_scan_display;

  localparam int DIV = 4;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] display_syscall;
  logic [14:0] display_pc;
  logic        sel_pc, hex_mode;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp, busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  seg7_scan_display #(.REFRESH_DIV(DIV), .NUM_DIGITS(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .display_syscall(display_syscall), .display_pc(display_pc),
    .sel_pc(sel_pc), .hex_mode(hex_mode), .an(an), .seg(seg), .dp(dp), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Display image for a value: byte i = {dp, seg} of digit i.
  function automatic logic [63:0] render(input logic hex, input logic [31:0] v);
    int         dig [8];
    longint     x;
    int         msd;
    logic       ovf;
    logic [63:0] r;
    x   = v;
    ovf = !hex && (v > 32'd99999999);
    for (int i = 0; i < 8; i++) begin
      if (hex) dig[i] = int'((v >> (4 * i)) & 32'hF);
      else begin
        dig[i] = int'(x % 10);
        x = x / 10;
      end
    end
    msd = 0;
    for (int i = 0; i < 8; i++) if (dig[i] != 0) msd = i;
    if (ovf) msd = 7;
    for (int i = 0; i < 8; i++)
      r[8*i +: 8] = {!(ovf && i == 7), (i > msd) ? 7'h7F : GLYPH[dig[i]]};
    return r;
  endfunction

  // Behavioural model: busy countdown after each capture, image swap when it expires,
  // scan position from the edge count since reset.
  logic [33:0] cur_key, m_key;
  logic        m_valid;
  int          m_rem, m_k;
  logic [7:0][7:0] m_buf;
  logic [7:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp;

  assign cur_key = {sel_pc, hex_mode, sel_pc ? {17'b0, display_pc} : display_syscall};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k     <= 0;
      m_rem   <= 0;
      m_valid <= 1'b0;
      m_key   <= '0;
      m_buf   <= '1;
      e_an    <= 8'hFF;
      e_seg   <= 7'h7F;
      e_dp    <= 1'b1;
    end else begin
      e_an  <= ~(8'b1 << ((m_k / DIV) % 8));
      e_seg <= m_buf[(m_k / DIV) % 8][6:0];
      e_dp  <= m_buf[(m_k / DIV) % 8][7];
      m_k   <= m_k + 1;
      if (m_rem == 0) begin
        if (!m_valid || cur_key != m_key) begin
          m_key   <= cur_key;
          m_valid <= 1'b1;
          m_rem   <= hex_mode ? 1 : 33;
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_buf <= render(m_key[32], m_key[31:0]);
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("an",   64'(an),   64'(e_an));
      check("seg",  64'(seg),  64'(e_seg));
      check("dp",   64'(dp),   64'(e_dp));
      check("busy", 64'(busy), 64'(m_rem != 0));
    end
  end

  task automatic read_digit(input int d, output logic [6:0] s, output logic p);
    int n = 0;
    @(negedge clk);
    while (an !== ~(8'b1 << d) && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      total++;
      bad++;
      $display("FAIL digit_wait: digit %0d never lit, an=%0h", d, an);
    end
    s = seg;
    p = dp;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      bad++;
      $display("FAIL idle_wait: busy stuck high");
    end
  endtask

  logic [6:0] s;
  logic       p;
  int         n, t0, t1;

  initial begin
    rst_n = 1'b0; display_syscall = '0; display_pc = '0; sel_pc = 1'b0; hex_mode = 1'b0;

    // Model pins against hand-computed images.
    check("pin_hex",   render(1'b1, 32'h1234ABCD), 64'hF9A4B099_8883C6A1);
    check("pin_12345", render(1'b0, 32'd12345),    64'hFFFFFFF9_A4B09992);
    check("pin_ffff",  render(1'b0, 32'hFFFFFFFF), 64'h10999082_F8A49092);
    check("pin_zero",  render(1'b0, 32'd0),        64'hFFFFFFFF_FFFFFFC0);
    check("pin_max8",  render(1'b0, 32'd99999999), 64'h90909090_90909090);
    check("pin_ovf",   render(1'b0, 32'd100000000), 64'h40C0C0C0_C0C0C0C0);

    repeat (3) @(negedge clk);
    check("rst_an", 64'(an), 64'hFF);
    check("rst_seg", 64'(seg), 64'h7F);
    check("rst_dp", 64'(dp), 64'h1);
    check("rst_busy", 64'(busy), 64'h0);
    rst_n = 1'b1;

    // 1: zero in decimal after reset.
    repeat (36) @(negedge clk);
    read_digit(0, s, p); check("t1_d0", 64'(s), 64'h40);
    read_digit(3, s, p); check("t1_d3", 64'(s), 64'h7F);
    check("t1_dp", 64'(p), 64'h1);

    // 2: hex value, committed two cycles after capture.
    hex_mode = 1'b1; display_syscall = 32'h1234ABCD;
    @(negedge clk); check("t2_busy1", 64'(busy), 64'h1);
    @(negedge clk); check("t2_busy2", 64'(busy), 64'h0);
    read_digit(0, s, p); check("t2_d0", 64'(s), 64'h21);
    read_digit(7, s, p); check("t2_d7", 64'(s), 64'h79);

    // 3: decimal 12345, busy for exactly 33 cycles.
    hex_mode = 1'b0; display_syscall = 32'd12345;
    @(negedge clk);
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
    check("t3_busy_len", 64'(n), 64'd33);
    read_digit(4, s, p); check("t3_d4", 64'(s), 64'h79);
    read_digit(5, s, p); check("t3_d5", 64'(s), 64'h7F);
    read_digit(0, s, p); check("t3_d0", 64'(s), 64'h12);

    // 4: overflow, dp only on digit 7.
    display_syscall = 32'hFFFFFFFF;
    wait_idle();
    read_digit(7, s, p); check("t4_d7", 64'(s), 64'h10); check("t4_dp7", 64'(p), 64'h0);
    read_digit(6, s, p); check("t4_d6", 64'(s), 64'h19); check("t4_dp6", 64'(p), 64'h1);

    // 5: changes mid-conversion; only the latest value follows.
    display_syscall = 32'd1000;
    repeat (10) @(negedge clk); display_syscall = 32'd2000;
    repeat (10) @(negedge clk); display_syscall = 32'd3000;
    wait_idle(); repeat (3) @(negedge clk); wait_idle();
    read_digit(3, s, p); check("t5_d3", 64'(s), 64'h30);
    read_digit(4, s, p); check("t5_d4", 64'(s), 64'h7F);

    // 6: async reset mid-conversion, then scan period.
    display_syscall = 32'd55555;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_an", 64'(an), 64'hFF);
    check("t6_seg", 64'(seg), 64'h7F);
    check("t6_busy", 64'(busy), 64'h0);
    @(negedge clk); rst_n = 1'b1;
    read_digit(0, s, p); t0 = cyc;
    read_digit(1, s, p);
    read_digit(0, s, p); t1 = cyc;
    check("t6_period", 64'(t1 - t0), 64'd32);
    wait_idle();
    read_digit(0, s, p); check("t6_d0", 64'(s), 64'h12);

    // Random traffic checked by the every-cycle model.
    for (int it = 0; it < 40; it++) begin
      sel_pc     = 1'($urandom_range(0, 1));
      hex_mode   = 1'($urandom_range(0, 1));
      display_pc = 15'($urandom);
      case ($urandom_range(0, 3))
        0: display_syscall = $urandom_range(0, 99);
        1: display_syscall = $urandom_range(0, 99999);
        2: display_syscall = $urandom;
        default: display_syscall = 32'd99999999 + $urandom_range(0, 2);
      endcase
      repeat ($urandom_range(1, 50)) @(negedge clk);
    end
    repeat (80) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
